bcd_scroll_register: RTL and testbench

Parametrised N-digit BCD shift/rotate register that drives the scrolling seven-segment display path. It holds NDIG packed 4-bit digits and can parallel-load, rotate left or right, or shift in a serial digit. Shifts are paced by an internal prescaler so one shift occurs every DIV enabled cycles. It pulses a step tick on every shift and a wrap flag after each full revolution.

---
 rtl/bcd_scroll_pkg.sv | 24 ++
 rtl/bcd_tick_prescaler.sv | 44 ++++
 rtl/bcd_scroll_register.sv | 155 +++++++++++++++
 tb/tb_bcd_scroll_register.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_scroll_pkg.sv
// bcd_scroll_pkg
// Shared types and constants for the BCD scroll register and its prescaler.
//   mode_t   : shift mode as driven on the 2-bit mode port
//   digit_t  : one packed BCD digit
//   BCD_MAX  : largest legal BCD digit value
//   bcd_valid: true when a digit is a legal BCD value
package bcd_scroll_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD     = 2'b00,
        MODE_ROT_L    = 2'b01,
        MODE_ROT_R    = 2'b10,
        MODE_SHIFT_IN = 2'b11
    } mode_t;

    typedef logic [3:0] digit_t;

    localparam digit_t BCD_MAX = 4'd9;

    function automatic logic bcd_valid(input digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_tick_prescaler.sv
// bcd_tick_prescaler
// Counts enabled cycles and fires once every DIV of them. The count is frozen
// while en is low and forced to zero by clear. Also used by the display scan.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the count this cycle
//   clear      : return the count to zero (wins over en, suppresses fire)
//   fire       : combinational; high in the cycle whose edge completes a period
module bcd_tick_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic fire
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          term;

    always_comb begin
        term  = (cnt_q == TERM);
        fire  = en && !clear && term;
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = term ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_scroll_register.sv
// bcd_scroll_register
// NDIG-digit BCD register feeding the scrolling seven-segment path. Supports
// parallel load, rotate left/right and serial shift-in, paced by a prescaler
// so one shift happens every DIV enabled cycles.
// Build option: define BCD_CHECK_EN to replace non-BCD digits captured from
// load_data or ser_in with 0 and pulse err; otherwise values pass unchanged
// and err is held at 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : parallel load strobe (wins over a shift on the same edge)
//   load_data  : parallel image, digit i at bits [4i+3:4i]
//   mode       : 00 hold, 01 rotate left, 10 rotate right, 11 shift-in left
//   en         : prescaler advance enable
//   ser_in     : digit entering position 0 in shift-in mode
//   digits     : register contents
//   tick       : registered pulse alongside each shift's new contents
//   wrap       : registered pulse when the NDIG-th same-mode shift lands
//   err        : registered pulse when a non-BCD digit was replaced
module bcd_scroll_register
    import bcd_scroll_pkg::*;
#(
    parameter int                NDIG = 6,
    parameter int                DIV  = 1,
    parameter logic [4*NDIG-1:0] INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_data,
    input  logic [1:0]        mode,
    input  logic              en,
    input  logic [3:0]        ser_in,
    output logic [4*NDIG-1:0] digits,
    output logic              tick,
    output logic              wrap,
    output logic              err
);

    // Wide enough to hold NDIG transiently before it folds back to 0.
    localparam int SW = $clog2(NDIG + 1);

    mode_t               mode_e;
    logic                fire;
    digit_t [NDIG-1:0]   digits_q, digits_d;
    digit_t [NDIG-1:0]   load_img;
    digit_t              ser_digit;
    logic   [SW-1:0]     step_q, step_d, step_next;
    mode_t               last_mode_q, last_mode_d;
    logic                tick_q, tick_d;
    logic                wrap_q, wrap_d;

    assign mode_e = mode_t'(mode);

    bcd_tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en && (mode_e != MODE_HOLD)),
        .clear (load),
        .fire  (fire)
    );

`ifdef BCD_CHECK_EN
    logic load_bad;
    logic ser_ok;
    logic err_q, err_d;

    always_comb begin
        load_img = '0;
        load_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_valid(load_data[4*i +: 4])) begin
                load_img[i] = load_data[4*i +: 4];
            end else begin
                load_img[i] = '0;
                load_bad    = 1'b1;
            end
        end
        ser_ok    = bcd_valid(ser_in);
        ser_digit = ser_ok ? ser_in : '0;
        // err follows whatever was actually captured on this edge.
        if (load) begin
            err_d = load_bad;
        end else begin
            err_d = fire && (mode_e == MODE_SHIFT_IN) && !ser_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign load_img  = load_data;
    assign ser_digit = ser_in;
    assign err       = 1'b0;
`endif

    always_comb begin
        digits_d    = digits_q;
        step_d      = step_q;
        last_mode_d = last_mode_q;
        tick_d      = 1'b0;
        wrap_d      = 1'b0;
        // A shift in a new mode starts a fresh revolution and counts as one.
        step_next   = (mode_e == last_mode_q) ? step_q + 1'b1 : SW'(1);

        if (load) begin
            digits_d = load_img;
            step_d   = '0;
        end else if (fire) begin
            case (mode_e)
                MODE_ROT_L:    digits_d = {digits_q[NDIG-2:0], digits_q[NDIG-1]};
                MODE_ROT_R:    digits_d = {digits_q[0], digits_q[NDIG-1:1]};
                MODE_SHIFT_IN: digits_d = {digits_q[NDIG-2:0], ser_digit};
                default:       digits_d = digits_q;
            endcase
            tick_d      = 1'b1;
            last_mode_d = mode_e;
            if (step_next == SW'(NDIG)) begin
                wrap_d = 1'b1;
                step_d = '0;
            end else begin
                step_d = step_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q    <= INIT;
            step_q      <= '0;
            last_mode_q <= MODE_ROT_L;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            digits_q    <= digits_d;
            step_q      <= step_d;
            last_mode_q <= last_mode_d;
            tick_q      <= tick_d;
            wrap_q      <= wrap_d;
        end
    end

    assign digits = digits_q;
    assign tick   = tick_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_bcd_scroll_register.sv
// tb_bcd_scroll_register
// Directed bench for bcd_scroll_register: two instances (DIV=1 and DIV=3)
// share the stimulus and are checked against hand-computed digit images.
module tb_bcd_scroll_register;

    localparam logic [23:0] INIT_IMG = 24'h012344;

`ifdef BCD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [23:0] load_data;
    logic [1:0]  mode;
    logic        en;
    logic [3:0]  ser_in;

    logic [23:0] dig1, dig3;
    logic        tick1, tick3, wrap1, wrap3, err1, err3;

    int total = 0;
    int bad   = 0;

    logic [23:0] rl_seq [0:5] = '{24'h123440, 24'h234401, 24'h344012,
                                  24'h440123, 24'h401234, 24'h012344};
    logic [23:0] si_seq [0:5] = '{24'h549875, 24'h498755, 24'h987555,
                                  24'h875555, 24'h755555, 24'h555555};
    logic [23:0] rl2_seq [0:5] = '{24'h555775, 24'h557755, 24'h577555,
                                   24'h775555, 24'h755557, 24'h555577};
    logic        en_pat [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    bcd_scroll_register #(.NDIG(6), .DIV(1), .INIT(INIT_IMG)) u_div1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .mode      (mode),
        .en        (en),
        .ser_in    (ser_in),
        .digits    (dig1),
        .tick      (tick1),
        .wrap      (wrap1),
        .err       (err1)
    );

    bcd_scroll_register #(.NDIG(6), .DIV(3), .INIT(INIT_IMG)) u_div3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .mode      (mode),
        .en        (en),
        .ser_in    (ser_in),
        .digits    (dig3),
        .tick      (tick3),
        .wrap      (wrap3),
        .err       (err3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        load      = 1'b0;
        load_data = '0;
        mode      = 2'b00;
        en        = 1'b0;
        ser_in    = 4'h0;

        #12;
        check("rst_dig1", dig1, INIT_IMG);
        check("rst_dig3", dig3, INIT_IMG);
        check("rst_tick", tick1, 1'b0);
        check("rst_wrap", wrap1, 1'b0);
        check("rst_err",  err1, 1'b0);
        rst_n = 1'b1;
        step_clk();

        // Rotate left, DIV=1: full revolution, wrap on the sixth shift.
        mode = 2'b01;
        en   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step_clk();
            check($sformatf("rotl_dig_%0d", i), dig1, rl_seq[i]);
            check($sformatf("rotl_tick_%0d", i), tick1, 1'b1);
            check($sformatf("rotl_wrap_%0d", i), wrap1, (i == 5));
            check($sformatf("rotl_tick3_%0d", i), tick3, (i % 3 == 2));
        end
        check("rotl_dig3", dig3, 24'h234401);
        en = 1'b0;

        // Realign both instances, then rotate right on DIV=3 with en toggling.
        load      = 1'b1;
        load_data = 24'h012344;
        step_clk();
        check("ld_dig3", dig3, 24'h012344);
        check("ld_tick3", tick3, 1'b0);
        load = 1'b0;
        mode = 2'b10;
        for (int k = 0; k < 5; k++) begin
            en = en_pat[k];
            step_clk();
            check($sformatf("rotr_dig3_%0d", k), dig3, (k == 4) ? 24'h401234 : 24'h012344);
            check($sformatf("rotr_tick3_%0d", k), tick3, (k == 4));
        end
        check("rotr_dig1", dig1, 24'h344012);

        // Load on the edge where DIV=3 would fire: load wins, period restarts.
        en = 1'b1;
        step_clk();
        step_clk();
        load      = 1'b1;
        load_data = 24'h987654;
        step_clk();
        check("ldcol_dig3", dig3, 24'h987654);
        check("ldcol_tick3", tick3, 1'b0);
        check("ldcol_dig1", dig1, 24'h987654);
        check("ldcol_tick1", tick1, 1'b0);
        load = 1'b0;
        step_clk();
        check("ldcol_d1_dig3", dig3, 24'h987654);
        step_clk();
        check("ldcol_d2_dig3", dig3, 24'h987654);
        check("ldcol_d2_tick3", tick3, 1'b0);
        step_clk();
        check("ldcol_d3_dig3", dig3, 24'h498765);
        check("ldcol_d3_tick3", tick3, 1'b1);
        check("ldcol_d3_dig1", dig1, 24'h654987);

        // Shift-in 5 for a full revolution on DIV=1.
        mode   = 2'b11;
        ser_in = 4'h5;
        for (int i = 0; i < 6; i++) begin
            step_clk();
            check($sformatf("shin_dig_%0d", i), dig1, si_seq[i]);
            check($sformatf("shin_wrap_%0d", i), wrap1, (i == 5));
        end
        ser_in = 4'h7;
        step_clk();
        step_clk();
        check("shin7_dig", dig1, 24'h555577);
        check("shin7_wrap", wrap1, 1'b0);

        // Mode change mid-revolution restarts the step count.
        mode = 2'b01;
        for (int i = 0; i < 6; i++) begin
            step_clk();
            check($sformatf("chg_dig_%0d", i), dig1, rl2_seq[i]);
            check($sformatf("chg_wrap_%0d", i), wrap1, (i == 5));
        end

        // Non-BCD digit on load and on ser_in.
        en        = 1'b0;
        mode      = 2'b00;
        load      = 1'b1;
        load_data = 24'h01C345;
        step_clk();
        check("bcd_ld_dig", dig1, CHK ? 24'h010345 : 24'h01C345);
        check("bcd_ld_err", err1, CHK);
        load = 1'b0;
        step_clk();
        check("bcd_ld_err_clr", err1, 1'b0);
        mode   = 2'b11;
        ser_in = 4'hB;
        en     = 1'b1;
        step_clk();
        check("bcd_ser_dig", dig1, CHK ? 24'h103450 : 24'h1C345B);
        check("bcd_ser_err", err1, CHK);
        en = 1'b0;
        step_clk();
        check("bcd_ser_err_clr", err1, 1'b0);

        // Reset mid-revolution: immediate INIT, partial step count lost.
        mode   = 2'b01;
        ser_in = 4'h0;
        en     = 1'b1;
        step_clk();
        step_clk();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_dig1", dig1, INIT_IMG);
        check("midrst_dig3", dig3, INIT_IMG);
        check("midrst_tick1", tick1, 1'b0);
        step_clk();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step_clk();
            check($sformatf("postrst_dig_%0d", i), dig1, rl_seq[i]);
            check($sformatf("postrst_wrap_%0d", i), wrap1, (i == 5));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
